// File: rtl/fetch_queue.sv
// Instruction fetch front end: fetch PC, one outstanding imem request and a DEPTH-entry {pc, inst}
// FIFO. Defining FETCH_PERF_CNT_EN adds redirect_count and stall_count outputs.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned INST_W   = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [INST_W-1:0]        imem_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INST_W-1:0]        out_inst,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_next_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]              redirect_count,
    output logic [31:0]              stall_count,
`endif
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [31:0]       r_pc;
    logic [31:0]       r_tag;
    logic              r_inflight;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;
    logic [31:0]       r_mem_pc   [DEPTH];
    logic [INST_W-1:0] r_mem_inst [DEPTH];

    logic              w_push;
    logic              w_pop;
    logic [LW:0]       w_used;
    logic              w_unused_bits;

    // Credit counts the outstanding response as occupied; a same-cycle pop is not credited.
    assign w_used        = {1'b0, r_level} + {{LW{1'b0}}, r_inflight};
    assign imem_req      = !reset && !redirect_valid && (w_used < (LW+1)'(DEPTH));
    assign imem_addr     = r_pc;
    assign out_valid     = !reset && (r_level != '0);
    assign level         = reset ? '0 : r_level;
    assign w_pop         = out_valid && out_ready;
    // A redirect or reset at this edge discards the response arriving now.
    assign w_push        = r_inflight && !reset && !redirect_valid;
    assign out_inst      = r_mem_inst[r_rptr];
    assign out_pc        = r_mem_pc[r_rptr];
    assign out_next_pc   = out_pc + 32'd4;
    assign w_unused_bits = ^redirect_pc[1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_tag      <= '0;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
        end else if (redirect_valid) begin
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_pc  <= r_pc + 32'd4;
                r_tag <= r_pc;
            end
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_pc[r_wptr]   <= r_tag;
            r_mem_inst[r_wptr] <= imem_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_redirect_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_redirect_count <= '0;
            r_stall_count    <= '0;
        end else begin
            if (redirect_valid)          r_redirect_count <= r_redirect_count + 32'd1;
            if (out_valid && !out_ready) r_stall_count    <= r_stall_count + 32'd1;
        end
    end

    assign redirect_count = r_redirect_count;
    assign stall_count    = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes expected {pc, inst} entries, a negedge monitor
// pops and compares on every accepted head. Define FETCH_PERF_CNT_EN to cover the counters.
module tb_fetch_queue;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;
    logic [2:0]  level;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirect_count;
    logic [31:0] stall_count;
`endif

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0040_0000),
        .INST_W   (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_next_pc    (out_next_pc),
`ifdef FETCH_PERF_CNT_EN
        .redirect_count (redirect_count),
        .stall_count    (stall_count),
`endif
        .level          (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM: data = address + 100, one cycle after the request.
    always @(posedge clock) imem_data <= imem_addr + 32'd100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_unexpected: got pc %h expected no entry", out_pc);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", out_pc, e.pc);
                chk("pop_inst", out_inst, e.inst);
                chk("pop_next_pc", out_next_pc, e.pc + 32'd4);
            end
        end
    end

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic req_chk(input logic exp_req, input logic [31:0] exp_addr);
        exp_t e;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) begin
            chk("imem_addr", imem_addr, exp_addr);
            e.pc   = exp_addr;
            e.inst = exp_addr + 32'd100;
            sb.push_back(e);
        end
    endtask

    task automatic cyc(input logic exp_req, input logic [31:0] exp_addr);
        mid();
        req_chk(exp_req, exp_addr);
        nxt();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        mid();
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        nxt();
        nxt();
        sb.delete();
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        mid();
        chk("redir_imem_req", 32'(imem_req), 32'd0);
        nxt();
        sb.delete();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        // Reset release with continuous consumption.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            mid();
            req_chk(1'b1, 32'h0040_0000 + 32'(4 * i));
            if (i == 1) chk("s1_valid_c1", 32'(out_valid), 32'd0);
            if (i == 2) begin
                chk("s1_valid_c2", 32'(out_valid), 32'd1);
                chk("s1_pc_c2", out_pc, 32'h0040_0000);
                chk("s1_inst_c2", out_inst, 32'h0040_0064);
            end
            nxt();
        end

        // Consumer stalls for 10 cycles, then drains.
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            mid();
            req_chk(c < 4, 32'h0040_0000 + 32'(4 * c));
            if (c >= 2) chk("s2_head_stable", out_pc, 32'h0040_0000);
            if (c == 9) chk("s2_level_full", 32'(level), 32'd4);
            nxt();
        end
        out_ready = 1'b1;
        for (int c = 10; c < 18; c++) begin
            mid();
            req_chk(c >= 11, 32'h0040_0010 + 32'(4 * (c - 11)));
            chk("s2_drain_valid", 32'(out_valid), 32'd1);
            nxt();
        end

        // Redirect with 2 entries held and 1 response in flight.
        out_ready = 1'b0;
        do_reset();
        cyc(1'b1, 32'h0040_0000);
        cyc(1'b1, 32'h0040_0004);
        cyc(1'b1, 32'h0040_0008);
        mid();
        chk("s3_level_pre", 32'(level), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1003;
        nxt();
        sb.delete();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        mid();
        req_chk(1'b1, 32'h0000_1000);
        chk("s3_level_t1", 32'(level), 32'd0);
        chk("s3_valid_t1", 32'(out_valid), 32'd0);
        nxt();
        mid();
        req_chk(1'b1, 32'h0000_1004);
        chk("s3_valid_t2", 32'(out_valid), 32'd0);
        nxt();
        mid();
        req_chk(1'b1, 32'h0000_1008);
        chk("s3_valid_t3", 32'(out_valid), 32'd1);
        chk("s3_pc_t3", out_pc, 32'h0000_1000);
        nxt();
        cyc(1'b1, 32'h0000_100C);
        cyc(1'b1, 32'h0000_1010);

        // Back-to-back redirects: only the second target is fetched.
        do_redirect(32'h0000_2000);
        do_redirect(32'h0000_3006);
        cyc(1'b1, 32'h0000_3004);
        cyc(1'b1, 32'h0000_3008);
        mid();
        req_chk(1'b1, 32'h0000_300C);
        chk("s3_b2b_pc", out_pc, 32'h0000_3004);
        nxt();

        // Fetch PC wraps past 2^32.
        do_redirect(32'hFFFF_FFF8);
        cyc(1'b1, 32'hFFFF_FFF8);
        cyc(1'b1, 32'hFFFF_FFFC);
        mid();
        req_chk(1'b1, 32'h0000_0000);
        chk("s4_pc_fff8", out_pc, 32'hFFFF_FFF8);
        nxt();
        mid();
        req_chk(1'b1, 32'h0000_0004);
        chk("s4_pc_fffc", out_pc, 32'hFFFF_FFFC);
        chk("s4_next_pc_wrap", out_next_pc, 32'h0000_0000);
        nxt();
        cyc(1'b1, 32'h0000_0008);

        // Reset asserted one cycle after a request.
        do_reset();
        cyc(1'b1, 32'h0040_0000);
        reset = 1'b1;
        mid();
        chk("s5_rst_req", 32'(imem_req), 32'd0);
        chk("s5_rst_valid", 32'(out_valid), 32'd0);
        chk("s5_rst_level", 32'(level), 32'd0);
        nxt();
        sb.delete();
        reset = 1'b0;
        cyc(1'b1, 32'h0040_0000);
        cyc(1'b1, 32'h0040_0004);
        mid();
        req_chk(1'b1, 32'h0040_0008);
        chk("s5_first_pc", out_pc, 32'h0040_0000);
        nxt();
        cyc(1'b1, 32'h0040_000C);

`ifdef FETCH_PERF_CNT_EN
        // 5 stalled cycles, then 3 redirects.
        out_ready = 1'b0;
        do_reset();
        mid();
        chk("s6_rc_reset", redirect_count, 32'd0);
        chk("s6_sc_reset", stall_count, 32'd0);
        req_chk(1'b1, 32'h0040_0000);
        nxt();
        cyc(1'b1, 32'h0040_0004);
        cyc(1'b1, 32'h0040_0008);
        cyc(1'b1, 32'h0040_000C);
        cyc(1'b0, 32'h0);
        cyc(1'b0, 32'h0);
        cyc(1'b0, 32'h0);
        out_ready = 1'b1;
        do_redirect(32'h0000_0100);
        cyc(1'b1, 32'h0000_0100);
        do_redirect(32'h0000_0200);
        cyc(1'b1, 32'h0000_0200);
        do_redirect(32'h0000_0300);
        mid();
        req_chk(1'b1, 32'h0000_0300);
        chk("s6_redirect_count", redirect_count, 32'd3);
        chk("s6_stall_count", stall_count, 32'd5);
        nxt();
        cyc(1'b1, 32'h0000_0304);
        cyc(1'b1, 32'h0000_0308);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
